uart_recv: RTL and testbench
============================

Name: uart_recv

Overview:
- 8N1 UART receiver; the downstream partner of the team's `send` transmitter.
- Consumes the serial line that `send` drives and recovers parallel bytes.
- Oversamples at system clock rate. One bit lasts CLKS_PER_BIT clk cycles, which matches the transmitter's divide-by-16 bit clock.
- Delivers each byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be even and ≥ 4.
- DATA_BITS, 8: data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data  output  DATA_BITS  last correctly received byte
- valid  output  1  one-cycle pulse; data is new
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Reset (async, rst low):
  - state=IDLE, bit_cnt=0, clk_cnt=0.
  - data=0, valid=0, frame_err=0, busy=0.
  - Synchroniser flops = 1; armed=0.
  - Reset asserted mid-frame aborts the frame immediately; no valid or frame_err is produced for it.
- Input synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- armed flag: set when rx_s=1 in IDLE; cleared on leaving IDLE or on a framing error. A start is recognised only when armed, so a line held low (break or stuck low) never retriggers.
- States IDLE, START, DATA, STOP:
  - IDLE: armed and rx_s=0 → START, clk_cnt=0. Call this cycle t0. t0 is 2 clk after the pin edge.
  - START: clk_cnt counts up. At clk_cnt=CLKS_PER_BIT/2-1, sample rx_s:
    - rx_s=1 → false start; return to IDLE with nothing reported.
    - rx_s=0 → DATA, clk_cnt=0, bit_cnt=0.
  - DATA: at clk_cnt=CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift, so LSB-first arrival ends aligned). Then clk_cnt=0 and bit_cnt++. After bit DATA_BITS-1 → STOP.
  - STOP: at clk_cnt=CLKS_PER_BIT-1, sample rx_s:
    - 1 → data<=shift register; valid=1 for exactly the next cycle.
    - 0 → frame_err=1 for exactly the next cycle; data unchanged; armed stays 0.
    - Either way → IDLE.
- Timing: bit k is sampled at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT. valid or frame_err asserts at t0 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT + 1. With defaults that is t0+153, i.e. 155 clk after the pin falling edge.
- Back-to-back frames: a start bit arriving immediately after the stop sample is accepted. IDLE re-arms as soon as rx_s=1 (the stop bit itself is high).
- valid and frame_err are never high together. Neither is ever high for more than 1 cycle.
- data is stable between valid pulses.
- Widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is $clog2(DATA_BITS+1) bits. No wrap is reachable, because the counters reset on every state transition.
- The rx glitch filter is the mid-bit sample only; no majority vote.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - default CLKS_PER_BIT=16 and DATA_BITS=8, shared with `send`
  - IDLE_LEVEL=1'b1
- Sub-module uart_sync: 2-flop synchroniser with parameterised reset value 1, async active-low rst. Reusable for any asynchronous control input.

Test Plan:
- Frame 0xA5, 16 clk per bit, driven from a `send` instance in loopback → valid pulse 155 clk after the start edge; data=0xA5; frame_err=0; busy high throughout the frame.
- Frames 0x00 then 0xFF back-to-back with no idle gap → two valid pulses 160 clk apart; data=0x00 then 0xFF.
- rx low for 4 clk, then high (glitch) → no valid, no frame_err; busy high for ≤ 9 clk, then IDLE; next frame 0x3C is received correctly.
- Frame 0x3C with stop bit driven 0, rx then held low 50 clk → frame_err pulse at t0+153; data keeps the previous value; no new start until rx returns high; the following frame 0x81 → valid, data=0x81.
- rst pulled low during bit 4 of frame 0x5A → outputs 0 immediately; no pulse for the aborted frame; after release the next frame 0x5A → valid, data=0x5A.
- Idle line held high for 1000 clk → valid, frame_err and busy stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default frame geometry, line idle level.
package uart_pkg;

   // Receiver / transmitter frame phases
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Defaults shared with the send transmitter (divide-by-16 bit clock, 8N1)
   localparam int unsigned DEF_CLKS_PER_BIT = 16;
   localparam int unsigned DEF_DATA_BITS    = 8;

   // Level of an idle line and of a valid stop bit
   localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit control input.
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; reset to the input's inactive level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : uart_sync

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling at clk rate, one-cycle valid / frame_err strobes.
module uart_recv
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

   // Sample points: middle of the start bit, then one full bit period apart
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   state_t               state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 armed;
   logic                 rx_s;

   uart_sync #(
      .RST_VAL (IDLE_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Frame FSM with bit timing counters and registered strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         armed     <= 1'b0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;

         unique case (state)
            IDLE: begin
               // A start is only taken after the line has been seen idle,
               // so a held-low line cannot retrigger frames.
               if (armed && (rx_s != IDLE_LEVEL)) begin
                  state   <= START;
                  clk_cnt <= '0;
                  armed   <= 1'b0;
                  busy    <= 1'b1;
               end else if (rx_s == IDLE_LEVEL) begin
                  armed <= 1'b1;
               end
            end

            START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  if (rx_s == IDLE_LEVEL) begin
                     // Line went back high before mid start bit: glitch
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (clk_cnt == FULL_LAST) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == LAST_BIT) begin
                     state   <= STOP;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            STOP: begin
               if (clk_cnt == FULL_LAST) begin
                  clk_cnt <= '0;
                  state   <= IDLE;
                  busy    <= 1'b0;
                  if (rx_s == IDLE_LEVEL) begin
                     data  <= shreg;
                     valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     armed     <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            default: begin
               state   <= IDLE;
               clk_cnt <= '0;
               bit_cnt <= '0;
               armed   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule : uart_recv

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: bit-banged 8N1 frames with hand-derived timing.
module tb_uart_recv;

   localparam int unsigned CPB = 16;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int tests = 0;
   int fails = 0;

   int cyc = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int n_busy = 0;
   int n_both = 0;
   int n_long = 0;
   int last_valid = 0;
   int last_ferr = 0;
   logic prev_valid = 1'b0;
   logic prev_ferr = 1'b0;
   int t_start = 0;

   uart_recv #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: value n during the cycle after the n-th rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor sampled on the falling edge
   always @(negedge clk) begin
      if (valid) begin
         n_valid++;
         last_valid = cyc;
      end
      if (frame_err) begin
         n_ferr++;
         last_ferr = cyc;
      end
      if (busy) n_busy++;
      if (valid && frame_err) n_both++;
      if ((valid && prev_valid) || (frame_err && prev_ferr)) n_long++;
      prev_valid = valid;
      prev_ferr  = frame_err;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full frame, LSB first, stop bit level selectable; leaves rx at the stop level
   task automatic drive_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      t_start = cyc;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
   endtask

   int nv, nf, nb, v1;
   logic [7:0] b5a;

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      #3 rst = 1'b0;
      tick(3);
      check("reset_data", 32'(data), 32'h0);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_ferr", 32'(frame_err), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      rst = 1'b1;
      tick(20);

      // Frame 0xA5: timing, data, busy span
      nv = n_valid; nf = n_ferr; nb = n_busy;
      drive_frame(8'hA5, 1'b1);
      check("a5_count", 32'(n_valid - nv), 32'd1);
      check("a5_latency", 32'(last_valid - t_start), 32'd155);
      check("a5_data", 32'(data), 32'hA5);
      check("a5_noferr", 32'(n_ferr - nf), 32'd0);
      check("a5_busy_cycles", 32'(n_busy - nb), 32'd152);
      tick(10);

      // Back-to-back 0x00 then 0xFF
      nv = n_valid;
      drive_frame(8'h00, 1'b1);
      v1 = last_valid;
      check("b2b_data0", 32'(data), 32'h00);
      drive_frame(8'hFF, 1'b1);
      check("b2b_count", 32'(n_valid - nv), 32'd2);
      check("b2b_spacing", 32'(last_valid - v1), 32'd160);
      check("b2b_data1", 32'(data), 32'hFF);
      tick(10);

      // Glitch: 4 clk low
      nv = n_valid; nf = n_ferr; nb = n_busy;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(20);
      check("glitch_novalid", 32'(n_valid - nv), 32'd0);
      check("glitch_noferr", 32'(n_ferr - nf), 32'd0);
      check("glitch_busy_cycles", 32'(n_busy - nb), 32'd8);
      check("glitch_idle", 32'(busy), 32'h0);
      drive_frame(8'h3C, 1'b1);
      check("post_glitch_data", 32'(data), 32'h3C);
      check("post_glitch_count", 32'(n_valid - nv), 32'd1);
      tick(10);

      // Distinct byte so a wrongly loaded bad frame is visible
      drive_frame(8'h96, 1'b1);
      check("pre_ferr_data", 32'(data), 32'h96);
      tick(10);

      // Framing error: stop bit low, line held low afterwards
      nv = n_valid; nf = n_ferr;
      drive_frame(8'h3C, 1'b0);
      nb = n_busy;
      tick(50);
      check("ferr_count", 32'(n_ferr - nf), 32'd1);
      check("ferr_latency", 32'(last_ferr - t_start), 32'd155);
      check("ferr_novalid", 32'(n_valid - nv), 32'd0);
      check("ferr_data_kept", 32'(data), 32'h96);
      check("ferr_no_retrigger", 32'(n_busy - nb), 32'd0);
      rx = 1'b1;
      tick(20);
      drive_frame(8'h81, 1'b1);
      check("post_ferr_data", 32'(data), 32'h81);
      check("post_ferr_count", 32'(n_valid - nv), 32'd1);
      tick(10);

      // Reset during bit 4 of 0x5A
      nv = n_valid; nf = n_ferr;
      b5a = 8'h5A;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = b5a[i];
         tick(CPB);
      end
      rx = b5a[4];
      tick(CPB / 2);
      rst = 1'b0;
      #1;
      check("midrst_data", 32'(data), 32'h0);
      check("midrst_valid", 32'(valid), 32'h0);
      check("midrst_ferr", 32'(frame_err), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      tick(CPB / 2);
      for (int i = 5; i < 8; i++) begin
         rx = b5a[i];
         tick(CPB);
      end
      rx = 1'b1;
      tick(CPB);
      rst = 1'b1;
      tick(20);
      check("midrst_nopulse_v", 32'(n_valid - nv), 32'd0);
      check("midrst_nopulse_f", 32'(n_ferr - nf), 32'd0);
      drive_frame(8'h5A, 1'b1);
      check("post_rst_data", 32'(data), 32'h5A);
      check("post_rst_count", 32'(n_valid - nv), 32'd1);
      tick(10);

      // Idle line for 1000 clk
      nv = n_valid; nf = n_ferr; nb = n_busy;
      tick(1000);
      check("idle_valid", 32'(n_valid - nv), 32'd0);
      check("idle_ferr", 32'(n_ferr - nf), 32'd0);
      check("idle_busy", 32'(n_busy - nb), 32'd0);

      // Strobe properties over the whole run
      check("never_both", 32'(n_both), 32'd0);
      check("single_cycle", 32'(n_long), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_uart_recv
